// File: rtl/traffic_phase_ctrl_pkg.sv
// Phase codes and duration lookup shared by the traffic phase controller.
// A phase code doubles as the LED-driver state value.
package traffic_pkg;

  typedef enum logic [3:0] {
    NS_LEFT       = 4'd0,
    NS_LEFT_FL    = 4'd1,
    NS_STRAIGHT   = 4'd2,
    NS_STRAIGHT_FL = 4'd3,
    NS_RIGHT      = 4'd4,
    NS_RIGHT_FL   = 4'd5,
    NS_YELLOW     = 4'd6,
    EW_LEFT       = 4'd7,
    EW_LEFT_FL    = 4'd8,
    EW_STRAIGHT   = 4'd9,
    EW_STRAIGHT_FL = 4'd10,
    EW_RIGHT      = 4'd11,
    EW_RIGHT_FL   = 4'd12,
    EW_YELLOW     = 4'd13,
    ALL_RED       = 4'hF
  } phase_e;

  localparam logic [3:0] PH_ILLEGAL = 4'hE;

  function automatic logic [5:0] phase_dur(input logic [3:0] ph,
                                           input logic [5:0] t_green,
                                           input logic [5:0] t_flash,
                                           input logic [5:0] t_yellow,
                                           input logic [5:0] t_allred);
    logic [5:0] d;
    case (ph)
      NS_LEFT, NS_STRAIGHT, NS_RIGHT,
      EW_LEFT, EW_STRAIGHT, EW_RIGHT:          d = t_green;
      NS_LEFT_FL, NS_STRAIGHT_FL, NS_RIGHT_FL,
      EW_LEFT_FL, EW_STRAIGHT_FL, EW_RIGHT_FL: d = t_flash;
      NS_YELLOW, EW_YELLOW:                    d = t_yellow;
      default:                                 d = t_allred;
    endcase
    return d;
  endfunction

  // All-red clearance and the last yellow both hand over to NS-left.
  function automatic logic [3:0] next_phase(input logic [3:0] ph);
    logic [3:0] n;
    case (ph)
      EW_YELLOW, ALL_RED: n = NS_LEFT;
      default:            n = ph + 4'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_tick_gen.sv
// One-second prescaler: counts 0..TICK_CNT-1 while enabled, clear wins over enable.
module tick_gen #(
  parameter int TICK_CNT = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CNT - 1);

  logic [CW-1:0] cnt_r;

  assign tick = en & (cnt_r == LAST);

  // Prescaler counter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Intersection phase sequencer with per-second countdown and emergency all-red hold.
// Illegal code 14 recovers through an all-red clearance.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_CNT = 50_000_000,
  parameter int T_GREEN  = 15,
  parameter int T_FLASH  = 3,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en,
  input  logic       emerg,
  output logic [3:0] state,
  output logic [5:0] time_left,
  output logic       phase_done
);

  localparam bit CFG_OK = (T_GREEN  >= 1) && (T_GREEN  <= 63) &&
                          (T_FLASH  >= 1) && (T_FLASH  <= 63) &&
                          (T_YELLOW >= 1) && (T_YELLOW <= 63) &&
                          (T_ALLRED >= 1) && (T_ALLRED <= 63) &&
                          (TICK_CNT >= 1);

  if (!CFG_OK) begin : g_cfg_err
    $error("traffic_phase_ctrl: phase durations must be 1..63 and TICK_CNT >= 1");
  end

  localparam logic [5:0] D_GREEN  = 6'(T_GREEN);
  localparam logic [5:0] D_FLASH  = 6'(T_FLASH);
  localparam logic [5:0] D_YELLOW = 6'(T_YELLOW);
  localparam logic [5:0] D_ALLRED = 6'(T_ALLRED);

  logic [3:0] state_r, state_nxt_s;
  logic [5:0] time_left_r, time_left_nxt_s;
  logic       phase_done_r, phase_done_nxt_s;
  logic       tick_s, run_s, clr_s, hold_s;

  // Emergency hold is the only place time_left sits at zero.
  assign hold_s = (state_r == ALL_RED) && (time_left_r == 6'd0);

  // Prescaler control: any phase (re)load restarts the second boundary
  always_comb begin
    run_s = en & ~emerg;
    clr_s = emerg | hold_s | (state_r == PH_ILLEGAL);
  end

  tick_gen #(
    .TICK_CNT(TICK_CNT)
  ) u_tick_gen (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (run_s),
    .clr      (clr_s),
    .tick     (tick_s)
  );

  // Next phase, countdown and change pulse
  always_comb begin
    state_nxt_s      = state_r;
    time_left_nxt_s  = time_left_r;
    phase_done_nxt_s = 1'b0;
    if (emerg) begin
      state_nxt_s      = ALL_RED;
      time_left_nxt_s  = 6'd0;
      phase_done_nxt_s = (state_r != ALL_RED);
    end else if (state_r == PH_ILLEGAL) begin
      state_nxt_s      = ALL_RED;
      time_left_nxt_s  = D_ALLRED;
      phase_done_nxt_s = 1'b1;
    end else if (hold_s) begin
      time_left_nxt_s  = D_ALLRED;
    end else if (tick_s) begin
      if (time_left_r > 6'd1) begin
        time_left_nxt_s = time_left_r - 6'd1;
      end else begin
        state_nxt_s      = next_phase(state_r);
        time_left_nxt_s  = phase_dur(next_phase(state_r), D_GREEN, D_FLASH,
                                     D_YELLOW, D_ALLRED);
        phase_done_nxt_s = 1'b1;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Phase state registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r      <= ALL_RED;
      time_left_r  <= D_ALLRED;
      phase_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      time_left_r  <= time_left_nxt_s;
      phase_done_r <= phase_done_nxt_s;
    end
  end

  assign state      = state_r;
  assign time_left  = time_left_r;
  assign phase_done = phase_done_r;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomised scoreboard bench for traffic_phase_ctrl with a cycles-remaining reference model.
module tb_traffic_phase_ctrl;

  localparam int TICK = 4;
  localparam int TG = 3;
  localparam int TF = 2;
  localparam int TY = 1;
  localparam int TA = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       en = 1'b0;
  logic       emerg = 1'b0;
  logic [3:0] state;
  logic [5:0] time_left;
  logic       phase_done;

  int chk = 0;
  int err = 0;
  int cyc = 0;

  traffic_phase_ctrl #(
    .TICK_CNT(TICK), .T_GREEN(TG), .T_FLASH(TF), .T_YELLOW(TY), .T_ALLRED(TA)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .emerg(emerg),
    .state(state), .time_left(time_left), .phase_done(phase_done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { int st; int rem; bit hold; } mdl_t;
  typedef struct { int st; int tl; } evt_t;

  mdl_t m = '{15, TA * TICK, 1'b0};
  mdl_t m_nxt;
  evt_t exp_q[$];

  function automatic int dur_s(int st);
    if (st inside {0, 2, 4, 7, 9, 11}) return TG;
    if (st inside {1, 3, 5, 8, 10, 12}) return TF;
    if (st inside {6, 13}) return TY;
    return TA;
  endfunction

  function automatic int exp_tl(mdl_t c);
    return c.hold ? 0 : (c.rem + TICK - 1) / TICK;
  endfunction

  // Model: each phase is a budget of cycles; seconds shown are the ceiling.
  function automatic mdl_t step(mdl_t c, logic e, logic x);
    mdl_t n = c;
    if (x) begin
      n.st = 15; n.rem = 0; n.hold = 1'b1;
    end else if (c.hold) begin
      n.hold = 1'b0; n.rem = TA * TICK;
    end else if (e) begin
      n.rem = c.rem - 1;
      if (n.rem <= 0) begin
        n.st  = (c.st >= 13) ? 0 : c.st + 1;
        n.rem = dur_s(n.st) * TICK;
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input int req);
    chk++;
    if (act !== 32'(req)) begin
      err++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  always_comb m_nxt = step(m, en, emerg);

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m <= '{15, TA * TICK, 1'b0};
      exp_q.delete();
    end else begin
      if (m_nxt.st != m.st) exp_q.push_back('{m_nxt.st, exp_tl(m_nxt)});
      m <= m_nxt;
    end
  end

  // Monitor: every cycle against the model, every pulse against the queue.
  always @(negedge sys_clk) begin : monitor
    evt_t e;
    if (sys_rst_n) begin
      check("state", 32'(state), m.st);
      check("time_left", 32'(time_left), exp_tl(m));
      if (phase_done) begin
        if (exp_q.size() == 0) begin
          check("pd_unexpected", 32'(phase_done), 0);
        end else begin
          e = exp_q.pop_front();
          check("pd_state", 32'(state), e.st);
          check("pd_time_left", 32'(time_left), e.tl);
        end
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        check("pd_missing", 32'(phase_done), 1);
      end
    end
  end

  task automatic wait_pd(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!phase_done && n < maxc);
    check("pd_wait", 32'(phase_done), 1);
  endtask

  task automatic wait_state(input int s, input int maxc);
    int n = 0;
    while (state !== 4'(s) && n < maxc) begin
      @(negedge sys_clk);
      n++;
    end
    check("reach_state", 32'(state), s);
  endtask

  initial begin
    int n, npd, prev, c0, burst;
    logic [5:0] tl0;
    burst = 0;

    repeat (3) @(negedge sys_clk);
    check("rst_state", 32'(state), 15);
    check("rst_time_left", 32'(time_left), TA);
    check("rst_phase_done", 32'(phase_done), 0);
    sys_rst_n = 1'b1;
    en = 1'b1;
    wait_pd(20, n);
    check("release_cycles", n, TA * TICK);
    check("first_state", 32'(state), 0);
    check("first_time_left", 32'(time_left), TG);

    // One full cycle with per-phase lengths
    c0 = cyc; npd = 0;
    do begin
      prev = int'(state);
      wait_pd(64, n);
      check("phase_len", n, dur_s(prev) * TICK);
      npd++;
    end while (state !== 4'd0 && npd < 20);
    check("cycle_pulses", npd, 14);
    check("cycle_len", cyc - c0, 128);

    // Enable low for 5 cycles inside state 2
    c0 = cyc;
    wait_state(2, 100);
    repeat (3) @(negedge sys_clk);
    tl0 = time_left;
    en = 1'b0;
    repeat (5) begin
      @(negedge sys_clk);
      check("en_low_time_left", 32'(time_left), int'(tl0));
      check("en_low_pd", 32'(phase_done), 0);
    end
    en = 1'b1;
    npd = 0;
    do begin
      wait_pd(64, n);
      npd++;
    end while (state !== 4'd0 && npd < 20);
    check("delayed_cycle_len", cyc - c0, 133);

    // Randomised enable and emergency bursts
    for (int i = 0; i < 600; i++) begin
      @(negedge sys_clk);
      if (burst > 0) burst--;
      else if ($urandom_range(0, 99) == 0) burst = int'($urandom_range(1, 12));
      emerg = (burst > 0);
      en = ($urandom_range(0, 7) != 0);
    end
    emerg = 1'b0;
    en = 1'b1;

    // Emergency during state 9
    wait_state(9, 400);
    repeat (2) @(negedge sys_clk);
    emerg = 1'b1;
    @(negedge sys_clk);
    check("emerg_state", 32'(state), 15);
    check("emerg_time_left", 32'(time_left), 0);
    check("emerg_pd", 32'(phase_done), 1);
    repeat (9) @(negedge sys_clk);
    emerg = 1'b0;
    @(negedge sys_clk);
    check("clear_time_left", 32'(time_left), TA);
    wait_pd(20, n);
    check("clear_cycles", n, TA * TICK);
    check("clear_exit_state", 32'(state), 0);

    // Emergency re-asserted 3 cycles into clearance
    emerg = 1'b1;
    repeat (3) @(negedge sys_clk);
    emerg = 1'b0;
    @(negedge sys_clk);
    repeat (3) @(negedge sys_clk);
    emerg = 1'b1;
    @(negedge sys_clk);
    check("reassert_time_left", 32'(time_left), 0);
    check("reassert_pd", 32'(phase_done), 0);
    repeat (3) @(negedge sys_clk);
    emerg = 1'b0;
    @(negedge sys_clk);
    check("restart_time_left", 32'(time_left), TA);
    wait_pd(20, n);
    check("restart_cycles", n, TA * TICK);
    check("restart_exit_state", 32'(state), 0);

    // Asynchronous reset in state 11
    wait_state(11, 200);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 15);
    check("async_rst_time_left", 32'(time_left), TA);
    check("async_rst_pd", 32'(phase_done), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_pd(20, n);
    check("rerelease_cycles", n, TA * TICK);
    check("rerelease_state", 32'(state), 0);
    check("rerelease_time_left", 32'(time_left), TG);

    repeat (4) @(negedge sys_clk);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
